sonar_echo_responder: RTL

//  Synthesizable HC-SR04-style ultrasonic sensor model: the responder end of the rover's trigger/echo

---
 rtl/rover_sonar_pkg.sv | 26 ++
 rtl/sonar_trig_sync.sv | 40 ++++
 rtl/sonar_echo_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rover_sonar_pkg.sv
// rover_sonar_pkg: state encoding, default cycle constants and LFSR
// helpers shared by the sonar responder and the ranger (macro: ECHO_JITTER_EN).
package rover_sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } sonar_state_e;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned TRIG_MIN    = 1_000;
    localparam int unsigned BURST_LEN   = 20_000;
    localparam int unsigned TIMEOUT     = 3_800_000;
    localparam int unsigned HOLDOFF_LEN = 1_000_000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sonar_trig_sync.sv
// sonar_trig_sync: two-flop synchroniser for the asynchronous trigger
// input, plus rise/fall detection on the synchronised level.
module sonar_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_in,
    output logic trig_s,
    output logic trig_rise,
    output logic trig_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // next values: shift the trigger through the chain
    always_comb begin
        sync1_d = trig_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // synchroniser and edge-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign trig_s    = sync2_q;
    assign trig_rise = sync2_q & ~prev_q;
    assign trig_fall = ~sync2_q & prev_q;

endmodule

// File: rtl/sonar_echo_responder.sv
// sonar_echo_responder: HC-SR04-style echo model; trigger in, echo pulse
// of programmed width out. Optional echo jitter: define ECHO_JITTER_EN.
module sonar_echo_responder
    import rover_sonar_pkg::*;
#(
    parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN,
    parameter int unsigned BURST_CYCLES    = BURST_LEN,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_LEN,
    parameter int unsigned JITTER_BITS     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [31:0] echo_cycles,
    input  logic        obj_present,
    output logic        echo,
    output logic        busy,
    output logic [15:0] pulse_count,
    output logic        short_trig
);

    sonar_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] width_q, width_d;
    logic        echo_q, echo_d;
    logic        short_q, short_d;
    logic [15:0] pcount_q, pcount_d;

    logic trig_s, trig_rise, trig_fall;
    logic [JITTER_BITS-1:0] jitter;
    logic [32:0] w_sum;
    logic [31:0] w_new;

    sonar_trig_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trigger),
        .trig_s    (trig_s),
        .trig_rise (trig_rise),
        .trig_fall (trig_fall)
    );

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign jitter = lfsr_q[JITTER_BITS-1:0];

    // LFSR advances only when a new echo width is latched
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == TRIG_HI && trig_fall
            && cnt_q >= TRIG_MIN_CYCLES) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // jitter LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign jitter = '0;
`endif

    // candidate echo width: pick source, add jitter, then clamp to [1, TIMEOUT]
    always_comb begin
        w_sum = obj_present ? {1'b0, echo_cycles}
                            : 33'(TIMEOUT_CYCLES);
        w_sum = w_sum + 33'(jitter);
        if (w_sum == 33'd0)
            w_new = 32'd1;
        else if (w_sum > 33'(TIMEOUT_CYCLES))
            w_new = TIMEOUT_CYCLES;
        else
            w_new = w_sum[31:0];
    end

    // next-state, counter, width latch and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        echo_d   = echo_q;
        pcount_d = pcount_q;
        short_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG_HI;
                    cnt_d   = 32'd1;
                end
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    if (cnt_q >= TRIG_MIN_CYCLES) begin
                        state_d = BURST;
                        cnt_d   = 32'd0;
                        width_d = w_new;
                    end else begin
                        state_d = IDLE;
                        short_d = 1'b1;
                    end
                end else if (trig_s && cnt_q < TRIG_MIN_CYCLES) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            BURST: begin
                if (cnt_q == BURST_CYCLES - 1) begin
                    state_d = ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ECHO: begin
                if (cnt_q == width_q - 32'd1) begin
                    state_d  = HOLDOFF;
                    echo_d   = 1'b0;
                    pcount_d = pcount_q + 16'd1;
                    cnt_d    = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLDOFF_CYCLES - 1) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                echo_d  = 1'b0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // state, counters and output registers; reset drops echo at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 32'd0;
            width_q  <= 32'd1;
            echo_q   <= 1'b0;
            short_q  <= 1'b0;
            pcount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            echo_q   <= echo_d;
            short_q  <= short_d;
            pcount_q <= pcount_d;
        end
    end

    assign echo        = echo_q;
    assign busy        = (state_q != IDLE);
    assign pulse_count = pcount_q;
    assign short_trig  = short_q;

endmodule
